dram_rd_arbiter: RTL

//  Shares the single DRAM read-command port (kick/busy/read_num/read_addr,
//  buf_dout/buf_we) between NUM_REQ burst-read clients, such as frame readers.

---
 rtl/dram_rd_arbiter_if.sv | 31 +++
 rtl/dram_rd_arbiter.sv | 83 ++++++++
 2 files changed

// File: rtl/dram_rd_arbiter_if.sv
// dram_rd_arbiter_if: client-side kick/busy/data signals plus the shared DRAM read-command port
// Ports (signals):
//   s_kick, s_read_addr, s_read_num   per-client request, byte address and word count (32 bits per client)
//   s_busy, s_buf_we, s_buf_dout      per-client busy and data strobe, broadcast return data
//   m_kick, m_read_addr, m_read_num   DRAM read command
//   m_busy, m_buf_dout, m_buf_we      DRAM busy and return data
// Modports: master = the arbiter, slave = the clients plus DRAM side that drive it.
interface dram_rd_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    s_kick;
    logic [NUM_REQ-1:0]    s_busy;
    logic [NUM_REQ-1:0]    s_buf_we;
    logic [32*NUM_REQ-1:0] s_read_addr;
    logic [32*NUM_REQ-1:0] s_read_num;
    logic [31:0]           s_buf_dout;
    logic                  m_kick;
    logic                  m_busy;
    logic                  m_buf_we;
    logic [31:0]           m_read_addr;
    logic [31:0]           m_read_num;
    logic [31:0]           m_buf_dout;
    modport master (
        input  s_kick, s_read_addr, s_read_num, m_busy, m_buf_we, m_buf_dout,
        output s_busy, s_buf_we, s_buf_dout, m_kick, m_read_addr, m_read_num
    );
    modport slave (
        output s_kick, s_read_addr, s_read_num, m_busy, m_buf_we, m_buf_dout,
        input  s_busy, s_buf_we, s_buf_dout, m_kick, m_read_addr, m_read_num
    );
endinterface

// File: rtl/dram_rd_arbiter.sv
// dram_rd_arbiter: round-robin sharing of one DRAM burst-read port between NUM_REQ clients
// Ports:
//   CLK, RST  clock and synchronous active-high reset
//   bus       client kick/busy/addr/num/data strobes and the shared DRAM read port
//   gnt_idx   index of the current or last granted client
//   err_cnt   sticky: a burst returned the wrong beat count, or data arrived while idle
module dram_rd_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int GNT_W   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    dram_rd_arbiter_if.master bus,
    output logic [GNT_W-1:0]  gnt_idx,
    output logic              err_cnt
);
    typedef enum logic [1:0] {IDLE, ISSUE, RUN} state_t;
    state_t           state, state_nx;
    logic [GNT_W-1:0] last, pick;
    logic             found, beat, done;
    logic [31:0]      sel_addr, sel_num, beats, beats_nx;
    int               best;
    // Ring distance from last+1; the nearest kicking client wins, so the last served ranks lowest.
    always_comb begin
        pick = '0;
        found = 1'b0;
        best = NUM_REQ;
        sel_addr = '0;
        sel_num = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (bus.s_kick[i] && (i + NUM_REQ - 1 - int'(last)) % NUM_REQ < best) begin
                best = (i + NUM_REQ - 1 - int'(last)) % NUM_REQ;
                pick = GNT_W'(i);
                found = 1'b1;
                sel_addr = bus.s_read_addr[32*i +: 32];
                sel_num = bus.s_read_num[32*i +: 32];
            end
        end
    end
    always_comb begin
        state_nx = state;
        state_nx = (state == IDLE) ? (found ? ISSUE : IDLE) :
                   (state == ISSUE) ? (bus.m_busy ? RUN : ISSUE) :
                   (bus.m_busy ? RUN : IDLE);
    end
    assign beat = bus.m_buf_we && state != IDLE;
    assign done = state == RUN && !bus.m_busy;
    // Saturating count; a beat landing on the completion cycle is still counted.
    assign beats_nx = beats + 32'(beat && beats != '1);
    assign bus.m_kick = state == ISSUE;
    assign bus.s_buf_dout = bus.m_buf_dout;
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_we
        assign bus.s_buf_we[i] = beat && gnt_idx == GNT_W'(i);
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            last <= GNT_W'(NUM_REQ - 1);
            gnt_idx <= '0;
            err_cnt <= 1'b0;
            beats <= '0;
            bus.s_busy <= '0;
            bus.m_read_addr <= '0;
            bus.m_read_num <= '0;
        end else begin
            state <= state_nx;
            beats <= beats_nx;
            if (state == IDLE && found) begin
                gnt_idx <= pick;
                bus.m_read_addr <= sel_addr;
                bus.m_read_num <= sel_num;
                bus.s_busy <= NUM_REQ'(1) << pick;
                beats <= '0;
            end
            if (done) begin
                bus.s_busy <= '0;
                last <= gnt_idx;
            end
            if ((done && beats_nx != bus.m_read_num) || (bus.m_buf_we && state == IDLE))
                err_cnt <= 1'b1;
        end
    end
endmodule
